redmule_z_collector: RTL

REDMULE_Z_COLLECTOR -- requirements
Module: redmule_z_collector

---
 rtl/redmule_z_collector_if.sv | 39 +++
 rtl/redmule_z_collector.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/redmule_z_collector_if.sv
// Handshake bundle between the Z element source, the line collector and the line consumer.
// line_nan_o exists only when REDMULE_ZCOLL_NAN_FLAG_EN is defined.
interface redmule_z_collector_if #(
    parameter int unsigned BITW  = 16,
    parameter int unsigned Width = 12,
    parameter int unsigned Depth = 2
) ();
    localparam int unsigned LenW = $clog2(Width + 1);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic                  flush_i;
    logic [LenW-1:0]       line_len_i;
    logic [BITW-1:0]       z_i;
    logic                  z_valid_i;
    logic                  z_ready_o;
    logic [Width*BITW-1:0] line_o;
    logic                  line_valid_o;
    logic                  line_ready_i;
    logic [CntW-1:0]       line_cnt_o;
`ifdef REDMULE_ZCOLL_NAN_FLAG_EN
    logic                  line_nan_o;
`endif

    modport master (
        output flush_i, line_len_i, z_i, z_valid_i, line_ready_i,
        input  z_ready_o, line_o, line_valid_o, line_cnt_o
`ifdef REDMULE_ZCOLL_NAN_FLAG_EN
        , line_nan_o
`endif
    );

    modport slave (
        input  flush_i, line_len_i, z_i, z_valid_i, line_ready_i,
        output z_ready_o, line_o, line_valid_o, line_cnt_o
`ifdef REDMULE_ZCOLL_NAN_FLAG_EN
        , line_nan_o
`endif
    );
endinterface

// File: rtl/redmule_z_collector.sv
// Packs streamed Z elements into lines of up to Width lanes and queues them in a Depth-line FIFO.
// Optional per-line NaN flag compiled in with REDMULE_ZCOLL_NAN_FLAG_EN.

package fpnew_pkg;
    typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

    function automatic int unsigned fp_width(input fp_format_e f);
        case (f)
            FP32:    return 32;
            FP64:    return 64;
            FP8:     return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int unsigned exp_bits(input fp_format_e f);
        case (f)
            FP32, FP16ALT: return 8;
            FP64:          return 11;
            default:       return 5;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e f);
        case (f)
            FP32:    return 23;
            FP64:    return 52;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 10;
        endcase
    endfunction
endpackage

module redmule_z_collector #(
    parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::FP16,
    parameter int unsigned           Width    = 12,
    parameter int unsigned           Depth    = 2
) (
    input logic                  clk_i,
    input logic                  rst_i,
    redmule_z_collector_if.slave zif
);
    localparam int unsigned BITW = fpnew_pkg::fp_width(FpFormat);
    localparam int unsigned LenW = $clog2(Width + 1);
    localparam int unsigned IdxW = $clog2(Width);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef enum logic {IDLE, FILL} state_e;

    state_e                     state_q, state_d;
    logic [IdxW-1:0]            idx_q;
    logic [LenW-1:0]            len_q;
    logic [Width-1:0][BITW-1:0] lane_q;
    logic [Width-1:0][BITW-1:0] mem_q [Depth];
    logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]            cnt_q;

    logic [LenW-1:0]            len_in, cur_len;
    logic                       last, full, ready, accept, commit, pop;
    logic [Width-1:0][BITW-1:0] line_new;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin : state_reg
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        if (zif.flush_i) begin
            state_d = IDLE;
        end else if (accept) begin
            case (state_q)
                IDLE:    if (!last) state_d = FILL;
                FILL:    if (last)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake control; in IDLE the incoming length decides whether this accept closes the line.
    always_comb begin : ctrl_out
        len_in = zif.line_len_i;
        if (zif.line_len_i == '0)                 len_in = LenW'(1);
        else if (zif.line_len_i > LenW'(Width))   len_in = LenW'(Width);
        cur_len = (state_q == IDLE) ? len_in : len_q;
        last    = (idx_q == IdxW'(cur_len - LenW'(1)));
        full    = (cnt_q == CntW'(Depth));
        ready   = !(full && last);
        accept  = zif.z_valid_i && ready;
        commit  = accept && last;
        pop     = (cnt_q != '0) && zif.line_ready_i;
    end

    // Lanes beyond the current one are zero, so short lines never carry stale data.
    always_comb begin : pack
        line_new = '0;
        for (int unsigned k = 0; k < Width; k++) begin
            if (IdxW'(k) < idx_q)       line_new[k] = lane_q[k];
            else if (IdxW'(k) == idx_q) line_new[k] = zif.z_i;
        end
    end

    always_ff @(posedge clk_i) begin : datapath
        if (rst_i) begin
            idx_q    <= '0;
            len_q    <= LenW'(1);
            lane_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned d = 0; d < Depth; d++) mem_q[d] <= '0;
        end else if (zif.flush_i) begin
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                lane_q[idx_q] <= zif.z_i;
                idx_q         <= last ? '0 : idx_q + IdxW'(1);
                if (state_q == IDLE) len_q <= cur_len;
            end
            if (commit) begin
                mem_q[wr_ptr_q] <= line_new;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (commit && !pop)      cnt_q <= cnt_q + CntW'(1);
            else if (pop && !commit) cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign zif.z_ready_o    = ready;
    assign zif.line_o       = mem_q[rd_ptr_q];
    assign zif.line_valid_o = (cnt_q != '0);
    assign zif.line_cnt_o   = cnt_q;

`ifdef REDMULE_ZCOLL_NAN_FLAG_EN
    localparam int unsigned ExpBits = fpnew_pkg::exp_bits(FpFormat);
    localparam int unsigned ManBits = fpnew_pkg::man_bits(FpFormat);

    logic             nan_q, z_nan;
    logic [Depth-1:0] nan_mem_q;

    assign z_nan = (&zif.z_i[BITW-2 -: ExpBits]) && (|zif.z_i[ManBits-1:0]);

    // Sticky NaN flag travels with its line through the FIFO.
    always_ff @(posedge clk_i) begin : nan_flag
        if (rst_i) begin
            nan_q     <= 1'b0;
            nan_mem_q <= '0;
        end else if (zif.flush_i) begin
            nan_q <= 1'b0;
        end else if (accept) begin
            nan_q <= last ? 1'b0 : (nan_q | z_nan);
            if (last) nan_mem_q[wr_ptr_q] <= nan_q | z_nan;
        end
    end

    assign zif.line_nan_o = nan_mem_q[rd_ptr_q];
`endif
endmodule
